// File: rtl/coord_intersect.sv
// Two-input coordinate intersector: joins two scanner coordinate/position streams,
// emitting only the coordinates present on both sides and passing stop/done tokens in lockstep.
module coord_intersect #(
    parameter int DATA_WIDTH = 17,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,

    input  logic [DATA_WIDTH-1:0] coord_in_0,
    input  logic                  coord_in_0_valid,
    output logic                  coord_in_0_ready,
    input  logic [DATA_WIDTH-1:0] pos_in_0,
    input  logic                  pos_in_0_valid,
    output logic                  pos_in_0_ready,

    input  logic [DATA_WIDTH-1:0] coord_in_1,
    input  logic                  coord_in_1_valid,
    output logic                  coord_in_1_ready,
    input  logic [DATA_WIDTH-1:0] pos_in_1,
    input  logic                  pos_in_1_valid,
    output logic                  pos_in_1_ready,

    output logic [DATA_WIDTH-1:0] coord_out,
    output logic                  coord_out_valid,
    input  logic                  coord_out_ready,
    output logic [DATA_WIDTH-1:0] pos_out_0,
    output logic                  pos_out_0_valid,
    input  logic                  pos_out_0_ready,
    output logic [DATA_WIDTH-1:0] pos_out_1,
    output logic                  pos_out_1_valid,
    input  logic                  pos_out_1_ready,

    output logic [CNT_WIDTH-1:0]  match_count,
    output logic                  err
);

    localparam int PW = DATA_WIDTH - 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_STOP = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] DONE_TOK = {1'b1, PW'(9'h100)};

    function automatic logic [1:0] kind_of(input logic [DATA_WIDTH-1:0] tok);
        if (!tok[DATA_WIDTH-1])
            return K_DATA;
        else if (tok == DONE_TOK)
            return K_DONE;
        else
            return K_STOP;
    endfunction

    logic [0:0]            state;
    logic                  active;
    logic                  present_0, present_1;
    logic                  fire, slots_free;
    logic [1:0]            kind_0, kind_1;
    logic                  mis_0, mis_1;
    logic                  pop_0, pop_1;
    logic                  emit, inc, set_err, go_done;
    logic [DATA_WIDTH-1:0] nxt_coord, nxt_pos_0, nxt_pos_1;
    logic [PW-1:0]         pay_0, pay_1;

    assign active     = clk_en & tile_en;
    assign present_0  = coord_in_0_valid & pos_in_0_valid;
    assign present_1  = coord_in_1_valid & pos_in_1_valid;
    assign fire       = active & present_0 & present_1 & (state == ST_RUN);
    assign slots_free = (~coord_out_valid | coord_out_ready)
                      & (~pos_out_0_valid | pos_out_0_ready)
                      & (~pos_out_1_valid | pos_out_1_ready);

    // A side is classified by its coord token; a differing pos kind is only flagged.
    assign kind_0 = kind_of(coord_in_0);
    assign kind_1 = kind_of(coord_in_1);
    assign mis_0  = kind_0 != kind_of(pos_in_0);
    assign mis_1  = kind_1 != kind_of(pos_in_1);
    assign pay_0  = coord_in_0[PW-1:0];
    assign pay_1  = coord_in_1[PW-1:0];

    always_comb begin
        pop_0     = 1'b0;
        pop_1     = 1'b0;
        emit      = 1'b0;
        inc       = 1'b0;
        set_err   = 1'b0;
        go_done   = 1'b0;
        nxt_coord = '0;
        nxt_pos_0 = '0;
        nxt_pos_1 = '0;
        if (fire) begin
            if (kind_0 == K_DATA && kind_1 == K_DATA) begin
                if (pay_0 == pay_1) begin
                    if (slots_free) begin
                        emit      = 1'b1;
                        inc       = 1'b1;
                        pop_0     = 1'b1;
                        pop_1     = 1'b1;
                        nxt_coord = coord_in_0;
                        nxt_pos_0 = pos_in_0;
                        nxt_pos_1 = pos_in_1;
                    end
                end else if (pay_0 < pay_1) begin
                    pop_0 = 1'b1;
                end else begin
                    pop_1 = 1'b1;
                end
            end else if (kind_0 == K_DATA) begin
                pop_0 = 1'b1;
            end else if (kind_1 == K_DATA) begin
                pop_1 = 1'b1;
            end else if (slots_free) begin
                emit  = 1'b1;
                pop_0 = 1'b1;
                pop_1 = 1'b1;
                if (kind_0 == K_STOP && kind_1 == K_STOP) begin
                    nxt_coord = coord_in_0;
                    set_err   = coord_in_0[7:0] != coord_in_1[7:0];
                end else begin
                    nxt_coord = DONE_TOK;
                    go_done   = 1'b1;
                    set_err   = kind_0 != kind_1;
                end
                nxt_pos_0 = nxt_coord;
                nxt_pos_1 = nxt_coord;
            end
            if ((pop_0 & mis_0) | (pop_1 & mis_1))
                set_err = 1'b1;
        end
    end

    assign coord_in_0_ready = pop_0;
    assign pos_in_0_ready   = pop_0;
    assign coord_in_1_ready = pop_1;
    assign pos_in_1_ready   = pop_1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state           <= ST_RUN;
            coord_out       <= '0;
            coord_out_valid <= 1'b0;
            pos_out_0       <= '0;
            pos_out_0_valid <= 1'b0;
            pos_out_1       <= '0;
            pos_out_1_valid <= 1'b0;
            match_count     <= '0;
            err             <= 1'b0;
        end else if (flush) begin
            state           <= ST_RUN;
            coord_out       <= '0;
            coord_out_valid <= 1'b0;
            pos_out_0       <= '0;
            pos_out_0_valid <= 1'b0;
            pos_out_1       <= '0;
            pos_out_1_valid <= 1'b0;
            match_count     <= '0;
            err             <= 1'b0;
        end else if (active) begin
            if (emit) begin
                coord_out       <= nxt_coord;
                pos_out_0       <= nxt_pos_0;
                pos_out_1       <= nxt_pos_1;
                coord_out_valid <= 1'b1;
                pos_out_0_valid <= 1'b1;
                pos_out_1_valid <= 1'b1;
            end else begin
                if (coord_out_ready) coord_out_valid <= 1'b0;
                if (pos_out_0_ready) pos_out_0_valid <= 1'b0;
                if (pos_out_1_ready) pos_out_1_valid <= 1'b0;
            end

            if (set_err)
                err <= 1'b1;

            case (state)
                ST_RUN: begin
                    if (inc && match_count != '1)
                        match_count <= match_count + 1'b1;
                    if (go_done)
                        state <= ST_DONE;
                end
                default: begin
                    match_count <= '0;
                    state       <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coord_intersect.sv
// Directed bench for coord_intersect: feeds paired token queues on both sides,
// captures every accepted output token and compares against hand-computed streams.
module tb_coord_intersect;

    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        tile_en = 1'b1;
    logic [16:0] coord_in_0 = '0, pos_in_0 = '0, coord_in_1 = '0, pos_in_1 = '0;
    logic        coord_in_0_valid = 1'b0, pos_in_0_valid = 1'b0;
    logic        coord_in_1_valid = 1'b0, pos_in_1_valid = 1'b0;
    logic        coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready;
    logic [16:0] coord_out, pos_out_0, pos_out_1;
    logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
    logic        coord_out_ready = 1'b1, pos_out_0_ready = 1'b1, pos_out_1_ready = 1'b1;
    logic [15:0] match_count;
    logic        err;

    coord_intersect #(.DATA_WIDTH(17), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
        .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
        .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
        .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
        .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
        .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
        .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready),
        .match_count(match_count), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] q_c0[$], q_p0[$], q_c1[$], q_p1[$];
    logic [16:0] got_c[$], got_p0[$], got_p1[$];
    logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];
    logic [15:0] mc_at_done;
    logic        done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [16:0] got[$], input logic [16:0] exp[$]);
        chk($sformatf("%s_len", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size())
                chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic clear_queues();
        q_c0.delete(); q_p0.delete(); q_c1.delete(); q_p1.delete();
        got_c.delete(); got_p0.delete(); got_p1.delete();
        done_seen = 1'b0;
        mc_at_done = '1;
    endtask

    // mode 0: outputs always ready, 1: pos_out_1_ready random, 2: pos_out_1_ready held low
    task automatic run(input int max_cycles, input int mode, input bit must_finish);
        int          n;
        logic        r0, r1, hold_v;
        logic [16:0] hold_val;
        n = 0;
        hold_v = 1'b0;
        hold_val = '0;
        while (n < max_cycles && (q_c0.size() > 0 || q_c1.size() > 0 ||
               coord_out_valid || pos_out_0_valid || pos_out_1_valid)) begin
            @(negedge clk);
            if (hold_v) begin
                chk("stall_valid", pos_out_1_valid, 1);
                chk("stall_data", pos_out_1, hold_val);
            end
            coord_in_0_valid = q_c0.size() > 0;
            pos_in_0_valid   = q_p0.size() > 0;
            coord_in_0       = (q_c0.size() > 0) ? q_c0[0] : '0;
            pos_in_0         = (q_p0.size() > 0) ? q_p0[0] : '0;
            coord_in_1_valid = q_c1.size() > 0;
            pos_in_1_valid   = q_p1.size() > 0;
            coord_in_1       = (q_c1.size() > 0) ? q_c1[0] : '0;
            pos_in_1         = (q_p1.size() > 0) ? q_p1[0] : '0;
            coord_out_ready  = 1'b1;
            pos_out_0_ready  = 1'b1;
            pos_out_1_ready  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            r0 = coord_in_0_ready & pos_in_0_ready;
            r1 = coord_in_1_ready & pos_in_1_ready;
            if (r0 && coord_in_0 == DN) begin
                mc_at_done = match_count;
                done_seen  = 1'b1;
            end
            if (coord_out_valid && coord_out_ready) got_c.push_back(coord_out);
            if (pos_out_0_valid && pos_out_0_ready) got_p0.push_back(pos_out_0);
            if (pos_out_1_valid && pos_out_1_ready) got_p1.push_back(pos_out_1);
            hold_v   = pos_out_1_valid && !pos_out_1_ready;
            hold_val = pos_out_1;
            @(posedge clk);
            if (r0) begin void'(q_c0.pop_front()); void'(q_p0.pop_front()); end
            if (r1) begin void'(q_c1.pop_front()); void'(q_p1.pop_front()); end
            n++;
        end
        @(negedge clk);
        coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0;
        coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
        if (must_finish)
            chk("timeout", n < max_cycles, 1);
    endtask

    task automatic load_basic();
        q_c0 = '{17'd0, 17'd2, 17'd5, S0, DN};
        q_p0 = '{17'd0, 17'd1, 17'd2, S0, DN};
        q_c1 = '{17'd2, 17'd3, 17'd5, S0, DN};
        q_p1 = '{17'd10, 17'd11, 17'd12, S0, DN};
    endtask

    task automatic check_basic(input string tag);
        exp_c  = '{17'd2, 17'd5, S0, DN};
        exp_p0 = '{17'd1, 17'd2, S0, DN};
        exp_p1 = '{17'd10, 17'd12, S0, DN};
        cmp({tag, "_c"}, got_c, exp_c);
        cmp({tag, "_p0"}, got_p0, exp_p0);
        cmp({tag, "_p1"}, got_p1, exp_p1);
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_mc_at_done"}, mc_at_done, 2);
        chk({tag, "_mc_after"}, match_count, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_coord_valid", coord_out_valid, 0);
        chk("rst_p0_valid", pos_out_0_valid, 0);
        chk("rst_p1_valid", pos_out_1_valid, 0);
        chk("rst_coord", coord_out, 0);
        chk("rst_mc", match_count, 0);
        chk("rst_err", err, 0);

        // basic match
        clear_queues();
        load_basic();
        run(100, 0, 1);
        check_basic("basic");

        // disjoint fibers
        clear_queues();
        q_c0 = '{17'd1, 17'd3, S0, DN};
        q_p0 = '{17'd0, 17'd1, S0, DN};
        q_c1 = '{17'd2, 17'd4, S0, DN};
        q_p1 = '{17'd5, 17'd6, S0, DN};
        run(100, 0, 1);
        exp_c = '{S0, DN};
        cmp("disj_c", got_c, exp_c);
        cmp("disj_p0", got_p0, exp_c);
        cmp("disj_p1", got_p1, exp_c);
        chk("disj_mc_at_done", mc_at_done, 0);

        // backpressure on pos_out_1
        clear_queues();
        load_basic();
        run(400, 1, 1);
        check_basic("bp");

        // multi-level stops
        clear_queues();
        q_c0 = '{17'd1, S0, 17'd2, S1, DN};
        q_p0 = '{17'd0, S0, 17'd1, S1, DN};
        q_c1 = '{17'd1, S0, 17'd3, S1, DN};
        q_p1 = '{17'd7, S0, 17'd8, S1, DN};
        run(100, 0, 1);
        exp_c  = '{17'd1, S0, S1, DN};
        exp_p0 = '{17'd0, S0, S1, DN};
        exp_p1 = '{17'd7, S0, S1, DN};
        cmp("ml_c", got_c, exp_c);
        cmp("ml_p0", got_p0, exp_p0);
        cmp("ml_p1", got_p1, exp_p1);
        chk("ml_err", err, 0);

        // stop level mismatch
        clear_queues();
        q_c0 = '{S0, DN}; q_p0 = '{S0, DN};
        q_c1 = '{S1, DN}; q_p1 = '{S1, DN};
        run(100, 0, 1);
        exp_c = '{S0, DN};
        cmp("perr_c", got_c, exp_c);
        chk("perr_err", err, 1);
        repeat (3) @(negedge clk);
        chk("perr_sticky", err, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_err", err, 0);

        // two tiles back-to-back, reset mid-way through the second
        clear_queues();
        load_basic();
        run(100, 0, 1);
        check_basic("tile1");
        clear_queues();
        load_basic();
        run(4, 2, 0);
        chk("tile2_stale_valid", pos_out_1_valid, 1);
        chk("tile2_stale_p1", pos_out_1, 10);
        chk("tile2_mc", match_count, 1);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_p1_valid", pos_out_1_valid, 0);
        @(negedge clk);
        rst_n = 1'b0;
        clear_queues();
        pos_out_1_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_c_valid", coord_out_valid, 0);
        chk("post_rst_p0_valid", pos_out_0_valid, 0);
        chk("post_rst_p1_valid", pos_out_1_valid, 0);
        chk("post_rst_c", coord_out, 0);
        chk("post_rst_p0", pos_out_0, 0);
        chk("post_rst_p1", pos_out_1, 0);
        chk("post_rst_mc", match_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
